arrmul_arbiter: RTL and testbench

Round-robin arbiter and pipeline controller that shares one signed array-multiplier datapath (WIDTH x WIDTH, two's-complement, 2*WIDTH-bit product) between N_REQ requesters. Each requester presents an operand pair over a valid/ready channel. The block grants one request per cycle, registers the operands, drives the shared combinational multiplier, and returns the product with the requester index on a single response channel with backpressure. It sits between the compute clients and the generated signed array multiplier, so one multiplier instance serves a whole cluster.

---
 rtl/arrmul_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_arrmul_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arrmul_arbiter.sv
// -----------------------------------------------------------------------------
// arrmul_arbiter
//
// Round-robin arbiter and pipeline controller that lets N_REQ requesters share
// one signed WIDTH x WIDTH array multiplier. One request is granted per cycle.
// The product (2*WIDTH bits, exact) is returned together with the index of the
// requester that issued it on a single response channel with backpressure.
// Responses come back in grant order.
//
// Build option:
//   ARRMUL_ARB_OPREG_EN  defined   : operand register stage S1 present,
//                                    latency 2, up to two operations in flight.
//                        undefined : multiplier fed straight from the granted
//                                    request, latency 1, one operation in flight.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [N_REQ]        request valid per requester
//   req_ready  out  [N_REQ]        grant/accept, one-hot or zero
//   req_a      in   [N_REQ*WIDTH]  operand a, slice i at [i*WIDTH +: WIDTH]
//   req_b      in   [N_REQ*WIDTH]  operand b, same packing
//   rsp_valid  out                 product valid
//   rsp_ready  in                  consumer accepts product
//   rsp_data   out  [2*WIDTH]      signed product a*b
//   rsp_id     out  [IDW]          requester index of the product
// -----------------------------------------------------------------------------
module arrmul_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 4,
   parameter int IDW   = $clog2(N_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req_valid,
   output logic [N_REQ-1:0]         req_ready,
   input  logic [N_REQ*WIDTH-1:0]   req_a,
   input  logic [N_REQ*WIDTH-1:0]   req_b,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [2*WIDTH-1:0]       rsp_data,
   output logic [IDW-1:0]           rsp_id
);

   localparam int PW = 2 * WIDTH;

   // ---------------------------------------------------------------------------
   // Unpack operand buses into per-requester arrays
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] a_arr [N_REQ];
   logic [WIDTH-1:0] b_arr [N_REQ];

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
         assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [IDW-1:0]   rr_q,        rr_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [PW-1:0]    rsp_data_q,  rsp_data_d;
   logic [IDW-1:0]   rsp_id_q,    rsp_id_d;

`ifdef ARRMUL_ARB_OPREG_EN
   logic             v1_q,  v1_d;
   logic [WIDTH-1:0] a1_q,  a1_d;
   logic [WIDTH-1:0] b1_q,  b1_d;
   logic [IDW-1:0]   id1_q, id1_d;
`endif

   // ---------------------------------------------------------------------------
   // Round-robin search: first valid requester at or after rr, wrapping.
   // Scanning from the far end downwards lets the nearest match win last.
   // ---------------------------------------------------------------------------
   logic [IDW-1:0] win_id;
   logic           win_found;

   always_comb begin
      int idx;
      idx       = 0;
      win_id    = '0;
      win_found = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = int'(rr_q) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (req_valid[idx]) begin
            win_id    = IDW'(idx);
            win_found = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Pipeline handshake
   // ---------------------------------------------------------------------------
   logic           s2_free;
   logic           can_accept;
   logic           accept;
   logic           s2_load;
   logic [IDW-1:0] s2_id_src;
   logic [WIDTH-1:0] mul_a, mul_b;
   logic [PW-1:0]  mul_p;

   assign s2_free = !rsp_valid_q || rsp_ready;

`ifdef ARRMUL_ARB_OPREG_EN
   assign can_accept = !v1_q || s2_free;
   assign s2_load    = v1_q && s2_free;
   assign s2_id_src  = id1_q;
   assign mul_a      = a1_q;
   assign mul_b      = b1_q;
`else
   assign can_accept = s2_free;
   assign s2_load    = accept;
   assign s2_id_src  = win_id;
   assign mul_a      = a_arr[win_id];
   assign mul_b      = b_arr[win_id];
`endif

   // rst_n gates the grant so nothing is handed out while the block is held
   // in reset, even though the pipeline then looks empty.
   assign accept = win_found && can_accept && rst_n;

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[win_id] = 1'b1;
   end

   // ---------------------------------------------------------------------------
   // Signed array multiplier: one shifted partial-product row per bit of b.
   // The MSB row carries negative weight in two's complement, so it is
   // subtracted instead of added. Result is exact modulo 2^PW, which is the
   // full product range.
   // ---------------------------------------------------------------------------
   logic [PW-1:0] a_ext;
   logic [PW-1:0] acc [WIDTH+1];

   assign a_ext  = {{WIDTH{mul_a[WIDTH-1]}}, mul_a};
   assign acc[0] = '0;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_row
         logic [PW-1:0] row;
         assign row = mul_b[gi] ? (a_ext << gi) : '0;
         if (gi == WIDTH - 1) begin : g_neg
            assign acc[gi+1] = acc[gi] - row;
         end else begin : g_pos
            assign acc[gi+1] = acc[gi] + row;
         end
      end
   endgenerate

   assign mul_p = acc[WIDTH];

   // ---------------------------------------------------------------------------
   // Next-state
   // ---------------------------------------------------------------------------
   always_comb begin
      rr_d        = rr_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_id_d    = rsp_id_q;

      if (accept) begin
         rr_d = (int'(win_id) == N_REQ - 1) ? '0 : win_id + 1'b1;
      end

      // S2 only changes when it is free; otherwise the stalled product holds.
      if (s2_free) begin
         rsp_valid_d = s2_load;
      end
      if (s2_load) begin
         rsp_data_d = mul_p;
         rsp_id_d   = s2_id_src;
      end
   end

`ifdef ARRMUL_ARB_OPREG_EN
   always_comb begin
      v1_d  = v1_q;
      a1_d  = a1_q;
      b1_d  = b1_q;
      id1_d = id1_q;
      if (s2_load) v1_d = 1'b0;
      // An accept in the same cycle as an advance refills S1 without a bubble.
      if (accept) begin
         v1_d  = 1'b1;
         a1_d  = a_arr[win_id];
         b1_d  = b_arr[win_id];
         id1_d = win_id;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q  <= 1'b0;
         a1_q  <= '0;
         b1_q  <= '0;
         id1_q <= '0;
      end else begin
         v1_q  <= v1_d;
         a1_q  <= a1_d;
         b1_q  <= b1_d;
         id1_q <= id1_d;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
      end else begin
         rr_q        <= rr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_id_q    <= rsp_id_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_arrmul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_arrmul_arbiter
//
// Self-checking bench for arrmul_arbiter. A transaction-level reference model
// (round-robin pointer, in-flight queue with capacity equal to the latency,
// integer multiplication) predicts req_ready, rsp_valid, rsp_data and rsp_id
// every cycle. Works with ARRMUL_ARB_OPREG_EN defined or undefined.
// -----------------------------------------------------------------------------
module tb_arrmul_arbiter;

   localparam int N   = 4;
   localparam int W   = 4;
   localparam int IDW = 2;
   localparam int PW  = 2 * W;
`ifdef ARRMUL_ARB_OPREG_EN
   localparam int D = 2;
`else
   localparam int D = 1;
`endif

   logic              clk;
   logic              rst_n;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N*W-1:0]    req_a;
   logic [N*W-1:0]    req_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [PW-1:0]     rsp_data;
   logic [IDW-1:0]    rsp_id;

   arrmul_arbiter #(.N_REQ(N), .WIDTH(W), .IDW(IDW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Reference model state
   // ---------------------------------------------------------------------------
   typedef struct {
      int            id;
      logic [PW-1:0] p;
      int            t;
   } item_t;

   item_t        q[$];
   int           rr_m;
   logic [N-1:0] acc_m;
   int           cyc;
   int           n_cmp;
   int           n_bad;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
      int sa, sb, p;
      sa = $signed(a);
      sb = $signed(b);
      p  = sa * sb;
      return PW'(p);
   endfunction

   // One clock cycle: compare at the falling edge, advance the model, then
   // return 1 time unit after the rising edge so the caller can drive inputs.
   task automatic step();
      int           w;
      bit           can;
      logic [N-1:0] exp_rdy;
      logic         exp_vld;
      item_t        it;
      @(negedge clk);
      w = -1;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (rr_m + k) % N;
         if (w < 0 && req_valid[idx]) w = idx;
      end
      can     = (q.size() < D) || rsp_ready;
      exp_rdy = '0;
      if (w >= 0 && can && rst_n) exp_rdy[w] = 1'b1;
      exp_vld = (q.size() > 0) && (cyc - q[0].t >= D);

      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
      if (exp_vld) begin
         chk("rsp_data", 32'(rsp_data), 32'(q[0].p));
         chk("rsp_id",   32'(rsp_id),   32'(q[0].id));
         if (rsp_ready)
            $display("rsp  cycle %0d id=%0d data=0x%02h", cyc, rsp_id, rsp_data);
      end

      if (exp_vld && rsp_ready) void'(q.pop_front());
      acc_m = exp_rdy;
      if (exp_rdy != '0) begin
         it.id = w;
         it.p  = ref_mul(req_a[w*W +: W], req_b[w*W +: W]);
         it.t  = cyc;
         q.push_back(it);
         rr_m = (w + 1) % N;
         $display("req  cycle %0d id=%0d a=0x%0h b=0x%0h", cyc, w, req_a[w*W +: W], req_b[w*W +: W]);
      end
      if (!rst_n) begin
         q.delete();
         rr_m = 0;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Requesters obey the protocol: a pending request holds valid and operands
   // until accepted; only then may it drop or present a fresh operation.
   task automatic stim(input logic [N-1:0] mask, input int pct);
      for (int i = 0; i < N; i++) begin
         if (!req_valid[i] || acc_m[i]) begin
            if (mask[i] && ($urandom_range(0, 99) < pct)) begin
               req_valid[i]      = 1'b1;
               req_a[i*W +: W]   = W'($urandom);
               req_b[i*W +: W]   = W'($urandom);
            end else begin
               req_valid[i] = 1'b0;
            end
         end
      end
   endtask

   task automatic send(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
      bit got;
      got = 1'b0;
      req_valid[id]    = 1'b1;
      req_a[id*W +: W] = a;
      req_b[id*W +: W] = b;
      for (int n = 0; n < 20 && !got; n++) begin
         step();
         got = acc_m[id];
      end
      if (!got) chk("send_timeout", 32'd0, 32'd1);
      req_valid[id] = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         stim('0, 0);
         step();
      end
   endtask

   int nacc;

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      cyc       = 0;
      rr_m      = 0;
      acc_m     = '0;
      rst_n     = 1'b0;
      req_valid = '1;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;

      // Reset state: no grant despite all valid, outputs at reset values
      step();
      chk("reset_rsp_data", 32'(rsp_data), 32'd0);
      chk("reset_rsp_id",   32'(rsp_id),   32'd0);
      step();

      // All four valid continuously from reset: grants 0,1,2,3,0,...
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         stim('1, 100);
         step();
      end
      idle(6);

      // Single request and corner operands
      send(0, 4'd3, 4'hE);
      idle(4);
      send(0, 4'h8, 4'h8);
      send(1, 4'h8, 4'h7);
      send(2, 4'h7, 4'h7);
      send(3, 4'h0, 4'h8);
      idle(5);

      // Backpressure: only as many accepts as the pipeline holds
      rsp_ready = 1'b0;
      nacc = 0;
      for (int i = 0; i < 5; i++) begin
         stim(4'b0011, 100);
         step();
         nacc += $countones(acc_m);
      end
      chk("bp_accepts", 32'(nacc), 32'(D));
      rsp_ready = 1'b1;
      idle(8);

      // Fairness: grant 1 to move rr to 2, then 1 and 3 alternate, 0 joins later
      send(1, 4'h2, 4'h5);
      for (int i = 0; i < 6; i++) begin
         stim(4'b1010, 100);
         step();
      end
      for (int i = 0; i < 8; i++) begin
         stim(4'b1011, 100);
         step();
      end
      idle(6);

      // Random traffic with random backpressure
      for (int i = 0; i < 400; i++) begin
         rsp_ready = ($urandom_range(0, 3) != 0);
         stim('1, 50);
         step();
      end
      rsp_ready = 1'b1;
      idle(10);

      // Reset while the pipeline is full
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         stim('1, 100);
         step();
      end
      rst_n = 1'b0;
      #1;
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midrst_req_ready", 32'(req_ready), 32'd0);
      chk("midrst_rsp_data",  32'(rsp_data),  32'd0);
      q.delete();
      rr_m      = 0;
      acc_m     = '0;
      req_valid = '0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      step();
      rst_n = 1'b1;
      send(2, 4'h5, 4'hD);
      idle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
